// File: rtl/decode_sequencer.sv
// decode_sequencer: decode-stage issue sequencer with serialization, fault halt and flush.
// Ports: clk/rst (sync, active-high); si_i/si_valid_i/si_ready_o fetch handshake;
// dec_si_o/dec_valid_o/dec_di_i drive and read back a combinational dynamic decoder;
// di_o/di_valid_o/di_ready_i registered issue handshake; pipe_empty_i, flush_i;
// fault_o pulse on accepting a faulting op; issued_cnt_o wrapping accept counter.
// Optional macro DECODE_SEQ_PERF_EN adds stall_cycles_o (saturating stall counter).
package C;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_LD, OP_ST, OP_BR,
      OP_SRET, OP_MRET, OP_DRET, OP_WFI, OP_FENCE_VMA
   } op_e;
   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [15:0] imm;
   } si_t;
   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic        fault;
   } di_t;
endpackage

module decode_sequencer #(
   parameter int ID_W = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  C::si_t          si_i,
   input  logic            si_valid_i,
   output logic            si_ready_o,
   output C::si_t          dec_si_o,
   output logic            dec_valid_o,
   input  C::di_t          dec_di_i,
   output C::di_t          di_o,
   output logic            di_valid_o,
   input  logic            di_ready_i,
   input  logic            pipe_empty_i,
   input  logic            flush_i,
   output logic            fault_o,
   output logic [ID_W-1:0] issued_cnt_o
`ifdef DECODE_SEQ_PERF_EN
   ,
   output logic [31:0]     stall_cycles_o
`endif
);
   typedef enum logic [1:0] {RUN, SERIAL, HALT} state_e;
   state_e          state_q, state_d;
   C::di_t          di_q, di_d;
   logic            di_valid_q, di_valid_d;
   logic [ID_W-1:0] cnt_q, cnt_d;
   logic            serial, accept;
   assign serial = si_i.op inside {C::OP_SRET, C::OP_MRET, C::OP_DRET, C::OP_WFI, C::OP_FENCE_VMA};
   // Serializing ops additionally wait for an empty output register and empty pipe.
   assign si_ready_o = !rst && state_q == RUN && !flush_i && (!di_valid_q || di_ready_i)
                       && (!serial || (pipe_empty_i && !di_valid_q));
   assign accept       = si_valid_i && si_ready_o;
   assign dec_si_o     = si_i;
   assign dec_valid_o  = accept;
   assign fault_o      = accept && dec_di_i.fault;
   assign di_o         = di_q;
   assign di_valid_o   = di_valid_q;
   assign issued_cnt_o = cnt_q;
   always_comb begin
      state_d    = flush_i                          ? RUN
                 : (state_q == RUN && accept)       ? (dec_di_i.fault ? HALT : serial ? SERIAL : RUN)
                 : (state_q == SERIAL && !di_valid_q && pipe_empty_i) ? RUN
                 : state_q;
      di_valid_d = flush_i ? 1'b0 : accept ? 1'b1 : di_ready_i ? 1'b0 : di_valid_q;
      di_d       = accept ? dec_di_i : di_q;
      cnt_d      = cnt_q + ID_W'(accept);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         di_q       <= '0;
         di_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         di_q       <= di_d;
         di_valid_q <= di_valid_d;
         cnt_q      <= cnt_d;
      end
   end
`ifdef DECODE_SEQ_PERF_EN
   logic [31:0] stall_q, stall_d;
   assign stall_d        = (si_valid_i && !si_ready_o && stall_q != '1) ? stall_q + 32'd1 : stall_q;
   assign stall_cycles_o = stall_q;
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`endif
endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst`; the reset SHALL be synchronous and active-high.
REQ-002 Parameter: ID_W, 20, width of the issued-instruction counter.
REQ-003 Port: clk  in  1  clock, all state on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: si_i  in  C::si_t  static instruction from fetch.
REQ-006 Port: si_valid_i  in  1  si_i valid.
REQ-007 Port: si_ready_o  out  1  si_i accepted when si_valid_i && si_ready_o.
REQ-008 Port: dec_si_o  out  C::si_t  instruction to the dynamic decoder, equal to si_i.
REQ-009 Port: dec_valid_o  out  1  decoder strobe, high exactly on accept cycles.
REQ-010 Port: dec_di_i  in  C::di_t  combinational decoder result for dec_si_o, fault flag included.
REQ-011 Port: di_o  out  C::di_t  registered decoded instruction to issue.
REQ-012 Port: di_valid_o  out  1  di_o valid.
REQ-013 Port: di_ready_i  in  1  downstream takes di_o when di_valid_o && di_ready_i.
REQ-014 Port: pipe_empty_i  in  1  no instruction in flight past decode.
REQ-015 Port: flush_i  in  1  redirect/flush from commit.
REQ-016 Port: fault_o  out  1  one-cycle pulse on accepting a faulting instruction.
REQ-017 Port: issued_cnt_o  out  ID_W  count of accepted instructions.

Function
REQ-018 FSM states SHALL be RUN, SERIAL, HALT.
REQ-019 Serializing op SHALL be the set SRET, MRET, DRET, WFI, FENCE_VMA.
REQ-020 si_ready_o SHALL be asserted only in RUN, with !flush_i and (!di_valid_o || di_ready_i).
REQ-021 For a serializing op in RUN, si_ready_o SHALL also require pipe_empty_i && !di_valid_o.
REQ-022 On accept, di_o SHALL load dec_di_i and di_valid_o SHALL be 1 the next cycle, giving 1-cycle latency.
REQ-023 Output register: if di_valid_o && di_ready_i and there is no accept, di_valid_o SHALL clear next cycle. Accept and take in the same cycle SHALL give back-to-back throughput.
REQ-024 RUN -> HALT on accept with dec_di_i.fault=1; the instruction SHALL still be forwarded with fault=1, and fault_o SHALL pulse in the accept cycle.
REQ-025 RUN -> SERIAL on accept of a non-faulting serializing op.
REQ-026 SERIAL -> RUN when !di_valid_o && pipe_empty_i, evaluated one cycle after the op leaves di_o at the earliest.
REQ-027 HALT SHALL remain until flush_i; HALT -> RUN on flush_i.
REQ-028 flush_i in any state SHALL clear di_valid_o next cycle and force RUN. Flush beats accept in the same cycle, so no accept occurs and dec_valid_o=0.
REQ-029 issued_cnt_o SHALL increment by 1 per accept, modulo 2^ID_W, with no saturation and unaffected by flush_i.
REQ-030 fault_o and dec_valid_o SHALL be combinational from the accept condition, so neither is asserted while flush_i is high.

Reset
REQ-031 On rst=1 the block SHALL enter RUN with di_valid_o=0, di_o=0, issued_cnt_o=0, fault_o=0, and stall counter 0 if present.
REQ-032 rst mid-operation SHALL drop any held instruction without a handshake; rst overrides flush_i.
REQ-033 si_ready_o SHALL be 0 during the reset cycle.

Configuration
REQ-034 With DECODE_SEQ_PERF_EN defined, the block SHALL add output stall_cycles_o (32 bits), counting cycles with si_valid_i && !si_ready_o, saturating at 2^32-1 and cleared by rst.
REQ-035 Without DECODE_SEQ_PERF_EN, stall_cycles_o and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Stream: 8 ADD instructions back-to-back, di_ready_i=1 -> di_valid_o high cycles 1..8; issued_cnt_o=8; fault_o never high.
REQ-037 Serialize: ADD, WFI, ADD with pipe_empty_i=0 until cycle 6 -> WFI accepted only after di_o drains and pipe_empty_i=1. Following ADD accepted only after WFI leaves di_o and pipe_empty_i=1 again (SERIAL).
REQ-038 Fault: MRET with dec_di_i.fault=1 -> fault_o pulses once; di_o.fault=1 next cycle; si_ready_o=0 until flush_i; after flush_i, RUN and next accept succeeds.
REQ-039 Backpressure: di_ready_i=0 for 5 cycles with si_valid_i=1 -> di_o stable; si_ready_o=0; stall_cycles_o=5 with DECODE_SEQ_PERF_EN.
REQ-040 Flush/accept collision: flush_i=1 and si_valid_i=1 same cycle, di_valid_o=1 -> no accept; di_valid_o=0 next cycle; issued_cnt_o unchanged.
REQ-041 Wrap and reset: ID_W=3, 9 accepts -> issued_cnt_o=1; rst pulse mid-stream -> all outputs at reset values next cycle.
